otter_fetch_unit: RTL

Program-counter and instruction-fetch sequencer for the OTTER CPU. Holds the PC and selects the next PC from PC+4, the jalr/branch/jal targets produced by the branch address generator, or the trap vectors MTVEC/MEPC. Fetches the instruction at the current PC over a request/grant/response handshake to instruction memory. Presents the instruction to the decoder and checks control-transfer targets for misalignment.

---
 rtl/otter_pkg.sv | 6 +
 rtl/otter_next_pc_mux.sv | 23 ++
 rtl/otter_fetch_unit.sv | 69 ++++++
 3 files changed

// File: rtl/otter_pkg.sv
// otter_pkg: shared types and constants for the OTTER fetch unit
package otter_pkg;
  typedef enum logic [2:0] {PC_PLUS4, PC_JALR, PC_BRANCH, PC_JAL, PC_MTVEC, PC_MEPC} pc_src_t;
  typedef enum logic [1:0] {FETCH, WAIT, READY} fetch_state_t;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
endpackage

// File: rtl/otter_next_pc_mux.sv
// otter_next_pc_mux: next-PC target selection, trap-vector alignment and misalignment detection
module otter_next_pc_mux import otter_pkg::*; (
  input  logic [31:0] pc_plus4,
  input  logic [2:0]  pc_source,
  input  logic [31:0] jalr,
  input  logic [31:0] branch,
  input  logic [31:0] jal,
  input  logic [31:0] mtvec,
  input  logic [31:0] mepc,
  output logic [31:0] target,
  output logic        misaligned
);
  pc_src_t src;
  always_comb begin
    src = pc_src_t'(pc_source);
    target = src == PC_JALR   ? jalr :
             src == PC_BRANCH ? branch :
             src == PC_JAL    ? jal :
             src == PC_MTVEC  ? mtvec & ~32'd3 :
             src == PC_MEPC   ? mepc & ~32'd3 : pc_plus4;
    misaligned = (src == PC_JALR || src == PC_BRANCH || src == PC_JAL) && |target[1:0];
  end
endmodule

// File: rtl/otter_fetch_unit.sv
// otter_fetch_unit: OTTER program counter and request/grant/response instruction fetch sequencer
module otter_fetch_unit import otter_pkg::*; #(
  parameter logic [31:0] RESET_VEC = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        PC_WRITE,
  input  logic [2:0]  PC_SOURCE,
  input  logic [31:0] JALR,
  input  logic [31:0] BRANCH,
  input  logic [31:0] JAL,
  input  logic [31:0] MTVEC,
  input  logic [31:0] MEPC,
  output logic        IMEM_REQ,
  output logic [31:0] IMEM_ADDR,
  input  logic        IMEM_GNT,
  input  logic        IMEM_RVALID,
  input  logic [31:0] IMEM_RDATA,
  output logic [31:0] IR,
  output logic        IR_VALID,
  output logic [31:0] PC,
  output logic [31:0] PC_PLUS4,
  output logic        MISALIGN
);
  fetch_state_t state, next_state;
  logic [31:0] target;
  logic misaligned, take, reject;
  assign PC_PLUS4 = PC + 32'd4;
  assign IMEM_REQ = state == FETCH;
  assign IMEM_ADDR = PC;
  otter_next_pc_mux u_mux (
    .pc_plus4(PC_PLUS4),
    .pc_source(PC_SOURCE),
    .jalr(JALR),
    .branch(BRANCH),
    .jal(JAL),
    .mtvec(MTVEC),
    .mepc(MEPC),
    .target(target),
    .misaligned(misaligned)
  );
  always_comb begin
    take = state == READY && PC_WRITE && !misaligned;
    reject = state == READY && PC_WRITE && misaligned;
    next_state = state == FETCH ? (IMEM_GNT ? WAIT : FETCH) :
                 state == WAIT  ? (IMEM_RVALID ? READY : WAIT) :
                 take ? FETCH : READY;
  end
  always_ff @(posedge CLK or posedge RST)
    if (RST) state <= FETCH;
    else state <= next_state;
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      PC <= RESET_VEC;
      IR <= NOP_INSTR;
      IR_VALID <= 1'b0;
      MISALIGN <= 1'b0;
    end else begin
      MISALIGN <= reject;
      if (take) begin
        PC <= target;
        IR_VALID <= 1'b0;
      end
      if (state == WAIT && IMEM_RVALID) begin
        IR <= IMEM_RDATA;
        IR_VALID <= 1'b1;
      end
    end
endmodule
